regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of a register-file write port.
// Up to N_REQ requesters compete for one write port; the winner's index and
// data are registered and presented one cycle after the grant. Writes to
// index 0 are accepted but never reach the write port. A saturating counter
// records cycles in which two or more requesters contended.
//
// Handshake: requester i transfers at a rising edge where req_valid[i] and
// req_ready[i] are both 1. A requester keeps idx/data stable while valid is
// high and ready is low. req_ready is combinational, at most one bit is set,
// and it is all zero while hold or rst is high.
module regfile_wb_arbiter #(
    parameter int N_BITS = 32,
    parameter int N_REQ  = 3,
    parameter int N_IDX  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*N_IDX-1:0]    req_idx,
    input  logic [N_REQ*N_BITS-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      hold,
    output logic                      wr_en,
    output logic [N_IDX-1:0]          wr_idx,
    output logic [N_BITS-1:0]         wr_data,
    output logic [15:0]               perf_conflicts
);

    localparam int PTR_W = $clog2(N_REQ);

    // Architectural state: priority pointer, output stage, contention counter.
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [N_IDX-1:0]  wr_idx_q, wr_idx_d;
    logic [N_BITS-1:0] wr_data_q, wr_data_d;
    logic [15:0]       perf_q, perf_d;

    // Arbitration intermediates.
    logic [N_REQ-1:0]  upper_mask;
    logic [N_REQ-1:0]  upper_req;
    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  hi_sel, lo_sel, gnt_sel;
    logic              hi_any, lo_any, xfer;
    logic [N_IDX-1:0]  gnt_idx;
    logic [N_BITS-1:0] gnt_data;
    logic              multi_req;

    // Round-robin pick: lowest valid requester at or above ptr, otherwise
    // wrap to the lowest valid requester overall.
    always_comb begin
        upper_mask = '0;
        hi_sel     = '0;
        lo_sel     = '0;
        hi_any     = 1'b0;
        lo_any     = 1'b0;
        grant      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            upper_mask[i] = (PTR_W'(i) >= ptr_q);
        end
        upper_req = req_valid & upper_mask;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                hi_any = 1'b1;
                hi_sel = PTR_W'(i);
            end
            if (req_valid[i]) begin
                lo_any = 1'b1;
                lo_sel = PTR_W'(i);
            end
        end
        gnt_sel = hi_any ? hi_sel : lo_sel;
        xfer    = lo_any && !hold && !rst;
        if (xfer) begin
            grant[gnt_sel] = 1'b1;
        end
    end

    // Select the granted requester's index and data from the packed buses.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == gnt_sel) begin
                gnt_idx  = req_idx[i*N_IDX +: N_IDX];
                gnt_data = req_data[i*N_BITS +: N_BITS];
            end
        end
    end

    // Two or more valid bits: clearing the lowest set bit leaves something.
    assign multi_req = |(req_valid & (req_valid - N_REQ'(1)));

    // Next-state: pointer advance, output stage load, contention count.
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        perf_d    = perf_q;
        if (xfer) begin
            ptr_d = (gnt_sel == PTR_W'(N_REQ - 1)) ? '0 : gnt_sel + PTR_W'(1);
            // Index 0 is a discarded write: accepted but never presented.
            if (gnt_idx != '0) begin
                wr_en_d   = 1'b1;
                wr_idx_d  = gnt_idx;
                wr_data_d = gnt_data;
            end
        end
        if (!hold && multi_req && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    // State registers with synchronous reset; reset also drops a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            perf_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            perf_q    <= perf_d;
        end
    end

    assign req_ready      = grant;
    assign wr_en          = wr_en_q;
    assign wr_idx         = wr_idx_q;
    assign wr_data        = wr_data_q;
    assign perf_conflicts = perf_q;

endmodule
